// File: rtl/mul4_share_arbiter.sv
// mul4_share_arbiter
//   Round-robin share of one combinational bit-sliced 2x2 multiplier among
//   NREQ requesters. The winning operand set is registered onto m_*, held for
//   one ISSUE cycle, and the multiplier result is captured and returned on a
//   single response channel tagged with the requester ID.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid / req_ready       per-requester request handshake (ready one-hot or 0)
//   req_a1/a0/b1/b0             packed operands, requester i at [i*LANES +: LANES]
//   m_a1/a0/b1/b0               registered operands to the shared multiplier
//   m_y3/y2/y1/y0               multiplier result (combinational from m_*)
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_y3..rsp_y0      response owner ID and captured result
//   op_count                    completed-operation counter, wraps
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | searching for a winner from rr_ptr; grant and latch operands
// ISSUE | operands stable on m_*; capture multiplier result at clock edge
// RESP  | response held on rsp_*; leave on rsp_ready, advance rr_ptr

module mul4_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int LANES = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*LANES-1:0] req_a1,
  input  logic [NREQ*LANES-1:0] req_a0,
  input  logic [NREQ*LANES-1:0] req_b1,
  input  logic [NREQ*LANES-1:0] req_b0,
  output logic [LANES-1:0]      m_a1,
  output logic [LANES-1:0]      m_a0,
  output logic [LANES-1:0]      m_b1,
  output logic [LANES-1:0]      m_b0,
  input  logic [LANES-1:0]      m_y3,
  input  logic [LANES-1:0]      m_y2,
  input  logic [LANES-1:0]      m_y1,
  input  logic [LANES-1:0]      m_y0,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [LANES-1:0]      rsp_y3,
  output logic [LANES-1:0]      rsp_y2,
  output logic [LANES-1:0]      rsp_y1,
  output logic [LANES-1:0]      rsp_y0,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr, grant_id, winner, rr_ptr_nx;
  logic             found;
  logic             accept, handshake;
  logic [LANES-1:0] sel_a1, sel_a0, sel_b1, sel_b0;
  int               idx;

  // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a1 = '0;
    sel_a0 = '0;
    sel_b1 = '0;
    sel_b0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a1 = req_a1[i*LANES +: LANES];
        sel_a0 = req_a0[i*LANES +: LANES];
        sel_b1 = req_b1[i*LANES +: LANES];
        sel_b0 = req_b0[i*LANES +: LANES];
      end
    end
  end

  assign accept    = (state == IDLE) && found;
  assign handshake = (state == RESP) && rsp_ready;
  assign rr_ptr_nx = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);

  // Qualified with rst_n so no grant is visible while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = rst_n && accept && (winner == IDW'(i));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      m_a1      <= '0;
      m_a0      <= '0;
      m_b1      <= '0;
      m_b0      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y3    <= '0;
      rsp_y2    <= '0;
      rsp_y1    <= '0;
      rsp_y0    <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        m_a1     <= sel_a1;
        m_a0     <= sel_a0;
        m_b1     <= sel_b1;
        m_b0     <= sel_b0;
        grant_id <= winner;
      end
      if (state == ISSUE) begin
        rsp_y3    <= m_y3;
        rsp_y2    <= m_y2;
        rsp_y1    <= m_y1;
        rsp_y0    <= m_y0;
        rsp_id    <= grant_id;
        rsp_valid <= 1'b1;
      end
      if (handshake) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
        rr_ptr    <= rr_ptr_nx;
      end
    end
  end

endmodule

// File: tb/tb_mul4_share_arbiter.sv
module tb_mul4_share_arbiter;
  localparam int NREQ = 4, LANES = 16, IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*LANES-1:0] req_a1 = '0, req_a0 = '0, req_b1 = '0, req_b0 = '0;
  logic [LANES-1:0] m_a1, m_a0, m_b1, m_b0, m_y3, m_y2, m_y1, m_y0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [LANES-1:0] rsp_y3, rsp_y2, rsp_y1, rsp_y0;
  logic [15:0] op_count;
  logic [LANES-1:0] c1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Golden per-lane 2x2 multiplier: {y3,y2,y1,y0} = {a1,a0} * {b1,b0}
  assign m_y0 = m_a0 & m_b0;
  assign m_y1 = (m_a1 & m_b0) ^ (m_a0 & m_b1);
  assign c1   = m_a1 & m_b0 & m_a0 & m_b1;
  assign m_y2 = (m_a1 & m_b1) ^ c1;
  assign m_y3 = m_a1 & m_b1 & c1;

  mul4_share_arbiter #(.NREQ(NREQ), .LANES(LANES), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a1(req_a1), .req_a0(req_a0), .req_b1(req_b1), .req_b0(req_b0),
    .m_a1(m_a1), .m_a0(m_a0), .m_b1(m_b1), .m_b0(m_b0),
    .m_y3(m_y3), .m_y2(m_y2), .m_y1(m_y1), .m_y0(m_y0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y3(rsp_y3), .rsp_y2(rsp_y2), .rsp_y1(rsp_y1), .rsp_y0(rsp_y0),
    .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a1, a0, b1, b0);
    req_a1[i*LANES +: LANES] = a1;
    req_a0[i*LANES +: LANES] = a0;
    req_b1[i*LANES +: LANES] = b1;
    req_b0[i*LANES +: LANES] = b0;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a1 = '0; req_a0 = '0; req_b1 = '0; req_b0 = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    step();
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0} !== 67'd0) begin
      errors++; $display("FAIL reset_rsp got v=%b id=%0d y=%h_%h_%h_%h want all 0",
                         rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0);
    end
    checks++;
    if ({m_a1, m_a0, m_b1, m_b0, op_count} !== 80'd0) begin
      errors++; $display("FAIL reset_regs got m=%h_%h_%h_%h cnt=%h want 0",
                         m_a1, m_a0, m_b1, m_b0, op_count);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_ops(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if ({rsp_valid, req_ready, m_a1, m_b0} !== {1'b0, 4'b0000, 16'hFFFF, 16'hFFFF}) begin
      errors++; $display("FAIL single_issue got v=%b rdy=%b a1=%h b0=%h want 0 0000 ffff ffff",
                         rsp_valid, req_ready, m_a1, m_b0);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0} !==
        {1'b1, 2'd2, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}) begin
      errors++; $display("FAIL single_rsp got v=%b id=%0d y=%h_%h_%h_%h want 1 2 ffff_0000_0000_ffff",
                         rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, op_count} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL single_done got v=%b cnt=%0d want 0 1", rsp_valid, op_count);
    end
  endtask

  task automatic test_mixed();
    set_ops(2, 16'h0, 16'h0, 16'h0, 16'h0);
    set_ops(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    set_ops(1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL mixed_ready got %b want 0010", req_ready);
    end
    step();
    req_valid = '0;
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0} !==
        {1'b1, 2'd1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL mixed_rsp got v=%b id=%0d y=%h_%h_%h_%h want 1 1 0000_0000_ffff_0000",
                         rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 16'd2) begin
      errors++; $display("FAIL mixed_count got %0d want 2", op_count);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_y0;
    logic [3:0]  exp_rdy;
    int          exp_id;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      exp_y0 = 16'h000F << (4 * i);
      set_ops(i, 16'h0, exp_y0, 16'h0, 16'hFFFF);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id  = k % NREQ;
      exp_rdy = 4'b0001 << exp_id;
      exp_y0  = 16'h000F << (4 * exp_id);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant op%0d got %b want %b", k, req_ready, exp_rdy);
      end
      step();
      step();
      checks++;
      if ({rsp_valid, rsp_id, rsp_y1, rsp_y0} !== {1'b1, 2'(exp_id), 16'h0, exp_y0}) begin
        errors++; $display("FAIL rr_rsp op%0d got v=%b id=%0d y1=%h y0=%h want 1 %0d 0000 %h",
                           k, rsp_valid, rsp_id, rsp_y1, rsp_y0, exp_id, exp_y0);
      end
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 16'd5) begin
      errors++; $display("FAIL rr_count got %0d want 5", op_count);
    end
  endtask

  task automatic test_backpressure();
    set_ops(3, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_grant got %b want 1000", req_ready);
    end
    step();
    req_valid = 4'b0001;
    step();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0, req_ready} !==
          {1'b1, 2'd3, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 4'b0000}) begin
        errors++; $display("FAIL bp_hold cyc%0d got v=%b id=%0d y=%h_%h_%h_%h rdy=%b want 1 3 0000_0000_ffff_ffff 0000",
                           c, rsp_valid, rsp_id, rsp_y3, rsp_y2, rsp_y1, rsp_y0, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, op_count, req_ready} !== {1'b0, 16'd6, 4'b0001}) begin
      errors++; $display("FAIL bp_release got v=%b cnt=%0d rdy=%b want 0 6 0001",
                         rsp_valid, op_count, req_ready);
    end
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_drop got %b want 0000", req_ready);
    end
  endtask

  task automatic test_async_reset();
    set_ops(2, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    set_ops(3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    set_ops(0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL ar_pre_grant got %b want 1000", req_ready);
    end
    step();
    checks++;
    if (m_a1 !== 16'hFFFF) begin
      errors++; $display("FAIL ar_issue got a1=%h want ffff", m_a1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, m_a1, m_a0, m_b1, m_b0, op_count, req_ready} !== 85'd0) begin
      errors++; $display("FAIL ar_clear got v=%b m=%h_%h_%h_%h cnt=%0d rdy=%b want all 0",
                         rsp_valid, m_a1, m_a0, m_b1, m_b0, op_count, req_ready);
    end
    step();
    step();
    checks++;
    if ({rsp_valid, req_ready} !== 5'd0) begin
      errors++; $display("FAIL ar_hold got v=%b rdy=%b want 0 0000", rsp_valid, req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL ar_first_grant got %b want 0001", req_ready);
    end
    req_valid = '0;
    step();
    step();
    checks++;
    if ({rsp_valid, op_count} !== 17'd0) begin
      errors++; $display("FAIL ar_no_rsp got v=%b cnt=%0d want 0 0", rsp_valid, op_count);
    end
  endtask

  task automatic test_wrap();
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    #1;
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload got %h want ffff", op_count);
    end
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y0} !== {1'b1, 2'd0, 16'hFFFF}) begin
      errors++; $display("FAIL wrap_rsp got v=%b id=%0d y0=%h want 1 0 ffff", rsp_valid, rsp_id, rsp_y0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_count got %h want 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mixed();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
